// File: rtl/seq_det_pkg.sv
// ============================================================================
//  Module   : seq_det_pkg
//  Purpose  : Shared types and reset-configuration constants for seq_det_ctrl
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam int MAXLEN_DEF = 8;
    localparam int CNTW_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Power-up detector setup: 4-bit pattern 1101, overlapping, free-running.
    localparam logic [31:0] c_RST_PATTERN = 32'b1101;
    localparam logic [3:0]  c_RST_LEN     = 4'd4;
    localparam logic        c_RST_OVERLAP = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_match_core.sv
// ============================================================================
//  Module   : seq_match_core
//  Purpose  : History shift register, bits-seen counter and masked compare
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clr,
    input  logic              din,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [3:0]        len,
    input  logic              overlap,
    output logic              match
);

    logic [MAXLEN-1:0] r_hist;
    logic [3:0]        r_seen;
    logic [MAXLEN-1:0] w_hist_next;
    logic [MAXLEN-1:0] w_mask;
    logic [3:0]        w_seen_next;
    logic              w_hit;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            w_mask[i] = (i < int'(len));
        end
    end

    // The match decision includes the bit being shifted in this cycle.
    assign w_hist_next = {r_hist[MAXLEN-2:0], din};
    assign w_seen_next = (r_seen >= len) ? r_seen : r_seen + 4'd1;
    assign w_hit       = (((w_hist_next ^ pattern) & w_mask) == '0) && (w_seen_next >= len);
    assign match       = shift_en & w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_seen <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_seen <= '0;
        end else if (shift_en) begin
            r_hist <= w_hist_next;
            r_seen <= (w_hit && !overlap) ? 4'd0 : w_seen_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_det_ctrl.sv
// ============================================================================
//  Module   : seq_det_ctrl
//  Purpose  : Programmable serial pattern detector with run/threshold FSM
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_thresh,
    output logic              cfg_err,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic              in,
    output logic              det,
    output logic [CNTW-1:0]   match_cnt,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    logic [MAXLEN-1:0] r_pattern;
    logic [3:0]        r_len;
    logic              r_overlap;
    logic [CNTW-1:0]   r_thresh;
    logic [CNTW-1:0]   r_cnt;
    logic              r_det;
    logic              r_cfg_err;

    logic              w_cfg_fire;
    logic              w_len_ok;
    logic              w_shift_en;
    logic              w_clr;
    logic              w_match;
    logic [CNTW-1:0]   w_cnt_inc;

    assign cfg_ready  = (r_state != ST_RUN);
    assign w_cfg_fire = cfg_valid & cfg_ready;
    assign w_len_ok   = (cfg_len != 4'd0) && (int'(cfg_len) <= MAXLEN);

    // Stop takes priority: the bit offered on a stop cycle is neither shifted nor matched.
    assign w_shift_en = (r_state == ST_RUN) & in_valid & ~stop;
    assign w_clr      = (r_state != ST_RUN) & start & ~stop;
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNTW'(1);

    seq_match_core #(
        .MAXLEN (MAXLEN)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_shift_en),
        .clr      (w_clr),
        .din      (in),
        .pattern  (r_pattern),
        .len      (r_len),
        .overlap  (r_overlap),
        .match    (w_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pattern <= MAXLEN'(c_RST_PATTERN);
            r_len     <= c_RST_LEN;
            r_overlap <= c_RST_OVERLAP;
            r_thresh  <= '0;
            r_cnt     <= '0;
            r_det     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_det     <= 1'b0;
            r_cfg_err <= w_cfg_fire & ~w_len_ok;

            if (w_cfg_fire && w_len_ok) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_thresh  <= cfg_thresh;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_match) begin
                        r_det <= 1'b1;
                        r_cnt <= w_cnt_inc;
                        if ((r_thresh != '0) && (w_cnt_inc == r_thresh)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign det       = r_det;
    assign cfg_err   = r_cfg_err;
    assign match_cnt = r_cnt;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);

endmodule

`default_nettype wire
